axi_rd_arbiter: RTL and testbench

Round-robin arbiter sharing the single AXI4 read channel pair (AR + R) of the memory-mapped slave among NUM_REQ upstream requesters. Grants one requester at a time, forwards its AR beat to the slave, then steers the full R burst back to that requester until RLAST completes. Sits between the requester-side bus fabric and the slave's read port. Only one burst is outstanding at any time.

---
 rtl/axi_rd_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin arbiter sharing one AXI4 read channel pair among NUM_REQ requesters
// Optional burst-length checker enabled by defining AXI_RD_ARB_BEAT_CHECK_EN.
module axi_rd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESTN,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ARADDR,
    input  logic [NUM_REQ*8-1:0]          REQ_ARLEN,
    input  logic [NUM_REQ*3-1:0]          REQ_ARSIZE,
    input  logic [NUM_REQ-1:0]            REQ_ARVALID,
    output logic [NUM_REQ-1:0]            REQ_ARREADY,
    output logic [DATA_WIDTH-1:0]         REQ_RDATA,
    output logic [1:0]                    REQ_RRESP,
    output logic                          REQ_RLAST,
    output logic [NUM_REQ-1:0]            REQ_RVALID,
    input  logic [NUM_REQ-1:0]            REQ_RREADY,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic [7:0]                    ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST,
    input  logic                          RVALID,
    output logic                          RREADY,
    output logic [NUM_REQ-1:0]            GRANT,
    output logic                          BEAT_ERR
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [2:0]              arsize_q, arsize_d;
    logic                    arvalid_q, arvalid_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;

    logic                    found;
    logic [IDX_W-1:0]        sel;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_len;
    logic [2:0]              sel_size;

    // Two passes: first the requesters at or after the pointer, then wrap to the low indices.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && REQ_ARVALID[i] && (IDX_W'(i) >= ptr_q)) begin
                found    = 1'b1;
                sel      = IDX_W'(i);
                sel_addr = REQ_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = REQ_ARLEN[i*8 +: 8];
                sel_size = REQ_ARSIZE[i*3 +: 3];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && REQ_ARVALID[i]) begin
                found    = 1'b1;
                sel      = IDX_W'(i);
                sel_addr = REQ_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = REQ_ARLEN[i*8 +: 8];
                sel_size = REQ_ARSIZE[i*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arvalid_d = arvalid_q;
        grant_d   = grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    araddr_d  = sel_addr;
                    arlen_d   = sel_len;
                    arsize_d  = sel_size;
                    arvalid_d = 1'b1;
                    grant_d   = NUM_REQ'(1) << sel;
                    ptr_d     = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (RVALID && RREADY && RLAST) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
            grant_q   <= grant_d;
        end
    end

    // Handshake steering is purely combinational so the arbiter adds no latency per beat.
    assign REQ_ARREADY = (state_q == ADDR) ? (grant_q & {NUM_REQ{ARREADY}}) : '0;
    assign REQ_RVALID  = (state_q == DATA) ? (grant_q & {NUM_REQ{RVALID}}) : '0;
    assign RREADY      = (state_q == DATA) && |(grant_q & REQ_RREADY);
    assign REQ_RDATA   = RDATA;
    assign REQ_RRESP   = RRESP;
    assign REQ_RLAST   = RLAST;
    assign ARADDR      = araddr_q;
    assign ARLEN       = arlen_q;
    assign ARSIZE      = arsize_q;
    assign ARVALID     = arvalid_q;
    assign GRANT       = grant_q;

`ifdef AXI_RD_ARB_BEAT_CHECK_EN
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       beat_err_q, beat_err_d;

    // Counter holds the beats still expected after the current one; it saturates at zero.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        beat_err_d = 1'b0;
        if (state_q == ADDR && ARREADY) begin
            beat_cnt_d = arlen_q;
        end else if (state_q == DATA && RVALID && RREADY) begin
            if (RLAST) begin
                beat_err_d = (beat_cnt_q != 8'd0);
            end else if (beat_cnt_q == 8'd0) begin
                beat_err_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) begin
            beat_cnt_q <= '0;
            beat_err_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            beat_err_q <= beat_err_d;
        end
    end

    assign BEAT_ERR = beat_err_q;
`else
    assign BEAT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter with random traffic and a round-robin model
module tb_axi_rd_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 16;

    logic            ACLK;
    logic            ARESTN;
    logic [N*AW-1:0] REQ_ARADDR;
    logic [N*8-1:0]  REQ_ARLEN;
    logic [N*3-1:0]  REQ_ARSIZE;
    logic [N-1:0]    REQ_ARVALID, REQ_ARREADY, REQ_RVALID, REQ_RREADY, GRANT;
    logic [DW-1:0]   REQ_RDATA, RDATA;
    logic [1:0]      REQ_RRESP, RRESP;
    logic            REQ_RLAST, RLAST, RVALID, RREADY, ARVALID, ARREADY, BEAT_ERR;
    logic [AW-1:0]   ARADDR;
    logic [7:0]      ARLEN;
    logic [2:0]      ARSIZE;

    axi_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESTN(ARESTN),
        .REQ_ARADDR(REQ_ARADDR), .REQ_ARLEN(REQ_ARLEN), .REQ_ARSIZE(REQ_ARSIZE),
        .REQ_ARVALID(REQ_ARVALID), .REQ_ARREADY(REQ_ARREADY),
        .REQ_RDATA(REQ_RDATA), .REQ_RRESP(REQ_RRESP), .REQ_RLAST(REQ_RLAST),
        .REQ_RVALID(REQ_RVALID), .REQ_RREADY(REQ_RREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .GRANT(GRANT), .BEAT_ERR(BEAT_ERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct { int who; logic [15:0] addr; logic [7:0] len; logic [2:0] size; } ar_t;
    typedef struct { int who; logic [31:0] data; logic [1:0] resp; logic last; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];

    int vectors = 0;
    int miscompares = 0;

    int          issued_cnt[N];
    int          done_cnt[N];
    logic [15:0] req_addr[N];
    logic [7:0]  req_len[N];
    logic [2:0]  req_size[N];
    int          force_delay = -1;
    int          trunc = -1;
    int          rr_mode = 0;
    int          ptr = 0;

    int arready_pulses = 0, err_pulses = 0, last_ar_cycles = 0, ar_cycles = 0, beats_seen = 0;
    int owner = 0;
    bit in_data = 0, post_last = 0, err_prev = 0, tog = 0;

    logic        smp_ar_hs, smp_r_hs, smp_rlast;
    logic [N-1:0] smp_req_hs;
    logic [15:0] smp_araddr;
    logic [7:0]  smp_arlen;
    bit          s_data = 0;
    int          s_beat = 0, s_last = 0, s_cnt = 0, s_delay = -1;
    logic [15:0] s_addr = '0;

    function automatic logic [31:0] beat_data(input logic [15:0] a, input int b);
        return {a, 8'(b), 8'hA5};
    endfunction

    function automatic logic [1:0] beat_resp(input logic [15:0] a, input int b);
        return 2'(b) ^ a[1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment: requester AR drivers, slave model and scoreboard monitor.
    initial begin
        REQ_ARVALID = '0; REQ_ARADDR = '0; REQ_ARLEN = '0; REQ_ARSIZE = '0; REQ_RREADY = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = '0;
        for (int i = 0; i < N; i++) begin issued_cnt[i] = 0; done_cnt[i] = 0; end
        forever begin
            @(negedge ACLK);
            smp_ar_hs  = ARVALID && ARREADY;
            smp_r_hs   = RVALID && RREADY;
            smp_rlast  = RLAST;
            smp_req_hs = REQ_ARVALID & REQ_ARREADY;
            smp_araddr = ARADDR;
            smp_arlen  = ARLEN;
            if (!ARESTN) begin
                exp_ar.delete(); exp_beat.delete();
                in_data = 0; post_last = 0; err_prev = 0; ar_cycles = 0;
            end else begin
                check("rready_mirror", 64'(RREADY), in_data ? 64'(REQ_RREADY[owner]) : 64'd0);
                check("req_rvalid", 64'(REQ_RVALID), (in_data && RVALID) ? 64'(1 << owner) : 64'd0);
                if (post_last) begin
                    check("turnaround_idle", 64'({GRANT, ARVALID}), 64'd0);
                    post_last = 0;
                end
                if (|REQ_ARREADY) arready_pulses++;
                if (BEAT_ERR) begin
                    check("beat_err_width", 64'(err_prev), 64'd0);
                    err_pulses++;
                end
                err_prev = BEAT_ERR;
                if (ARVALID) begin
                    ar_cycles++;
                    if (exp_ar.size() == 0) begin
                        check("ar_unexpected", 64'(ARVALID), 64'd0);
                    end else begin
                        check("ar_fields", 64'({ARADDR, ARLEN, ARSIZE, GRANT}),
                              64'({exp_ar[0].addr, exp_ar[0].len, exp_ar[0].size, N'(1 << exp_ar[0].who)}));
                        if (ARREADY) begin
                            check("req_arready", 64'(REQ_ARREADY), 64'(1 << exp_ar[0].who));
                            owner = exp_ar[0].who;
                            void'(exp_ar.pop_front());
                            in_data = 1;
                            last_ar_cycles = ar_cycles;
                            ar_cycles = 0;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (REQ_RVALID[i] && REQ_RREADY[i]) begin
                        if (exp_beat.size() == 0) begin
                            check("r_unexpected", 64'(REQ_RVALID[i]), 64'd0);
                        end else begin
                            beat_t b;
                            b = exp_beat.pop_front();
                            check("r_owner", 64'(i), 64'(b.who));
                            check("r_beat", 64'({REQ_RDATA, REQ_RRESP, REQ_RLAST}), 64'({b.data, b.resp, b.last}));
                            beats_seen++;
                            if (b.last) begin in_data = 0; post_last = 1; end
                        end
                    end
                end
            end
            @(posedge ACLK);
            #1;
            if (!ARESTN) begin
                for (int i = 0; i < N; i++) done_cnt[i] = issued_cnt[i];
                REQ_ARVALID = '0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
                s_data = 0; s_cnt = 0; s_delay = -1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (smp_req_hs[i]) done_cnt[i]++;
                    REQ_ARVALID[i]           = (issued_cnt[i] != done_cnt[i]);
                    REQ_ARADDR[i*AW +: AW]   = req_addr[i];
                    REQ_ARLEN[i*8 +: 8]      = req_len[i];
                    REQ_ARSIZE[i*3 +: 3]     = req_size[i];
                end
                tog = !tog;
                for (int i = 0; i < N; i++)
                    REQ_RREADY[i] = (rr_mode == 1) ? tog : ($urandom_range(0, 3) != 0);
                if (smp_ar_hs) begin
                    s_data = 1; s_beat = 0; s_addr = smp_araddr;
                    s_last = (trunc >= 0) ? trunc : int'(smp_arlen);
                    s_cnt = 0; s_delay = -1;
                end
                if (s_data && smp_r_hs) begin
                    if (smp_rlast) s_data = 0;
                    else s_beat++;
                end
                if (ARVALID && !s_data) begin
                    if (s_delay < 0) s_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                    ARREADY = (s_cnt >= s_delay);
                    s_cnt++;
                end else begin
                    ARREADY = 1'b0;
                end
                if (!s_data) RVALID = 1'b0;
                else if (!(RVALID && !smp_r_hs)) RVALID = ($urandom_range(0, 3) != 0);
                RDATA = beat_data(s_addr, s_beat);
                RRESP = beat_resp(s_addr, s_beat);
                RLAST = s_data && (s_beat == s_last);
            end
        end
    end

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic prep(input int i, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
        req_addr[i] = a; req_len[i] = l; req_size[i] = s;
    endtask

    // Reference: repeatedly take the first pending requester at or after ptr, wrapping.
    task automatic plan(input logic [N-1:0] mask);
        bit pend[N];
        int w, nb;
        for (int i = 0; i < N; i++) pend[i] = mask[i];
        forever begin
            w = -1;
            for (int k = 0; k < N; k++) if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
            if (w < 0) break;
            exp_ar.push_back('{w, req_addr[w], req_len[w], req_size[w]});
            nb = (trunc >= 0) ? trunc + 1 : int'(req_len[w]) + 1;
            for (int b = 0; b < nb; b++)
                exp_beat.push_back('{w, beat_data(req_addr[w], b), beat_resp(req_addr[w], b), b == nb - 1});
            pend[w] = 0;
            ptr = (w + 1) % N;
        end
    endtask

    task automatic issue(input logic [N-1:0] mask);
        @(negedge ACLK);
        for (int i = 0; i < N; i++) if (mask[i]) issued_cnt[i]++;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_ar.size() != 0 || exp_beat.size() != 0) && t < 3000) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 3000) begin
            vectors++; miscompares++;
            $display("FAIL wait_done: timeout with %0d AR and %0d beats outstanding", exp_ar.size(), exp_beat.size());
            finish_run();
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic launch(input logic [N-1:0] mask);
        plan(mask);
        issue(mask);
        wait_done();
    endtask

    initial begin
        int p0, e0, b0, t;
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) prep(i, '0, '0, '0);
        ARESTN = 1'b0;
        repeat (2) @(negedge ACLK);
        check("rst_ar", 64'({ARVALID, ARADDR, ARLEN, ARSIZE}), 64'd0);
        check("rst_grant", 64'(GRANT), 64'd0);
        check("rst_beat_err", 64'(BEAT_ERR), 64'd0);
        check("rst_r_side", 64'({RREADY, REQ_RVALID, REQ_ARREADY}), 64'd0);
        #2 ARESTN = 1'b1;
        ptr = 0;

        // Single request from requester 1, with arbitration latency
        prep(1, 16'h0010, 8'd3, 3'd2);
        plan(2'b10);
        issue(2'b10);
        @(negedge ACLK);
        check("lat_before", 64'(ARVALID), 64'd0);
        @(negedge ACLK);
        check("lat_after", 64'({ARVALID, GRANT}), 64'({1'b1, 2'b10}));
        wait_done();

        // Simultaneous requests alternate
        prep(0, 16'h0100, 8'd0, 3'd2); prep(1, 16'h0200, 8'd0, 3'd2);
        launch(2'b11);
        prep(0, 16'h0300, 8'd0, 3'd2); prep(1, 16'h0400, 8'd0, 3'd2);
        launch(2'b11);

        // R backpressure
        rr_mode = 1;
        prep(0, 16'h0500, 8'd7, 3'd2);
        launch(2'b01);
        rr_mode = 0;

        // Slow ARREADY
        force_delay = 5;
        p0 = arready_pulses;
        prep(1, 16'h0600, 8'd1, 3'd1);
        launch(2'b10);
        force_delay = -1;
        check("ar_wait_cycles", 64'(last_ar_cycles), 64'd6);
        check("req_arready_pulses", 64'(arready_pulses - p0), 64'd1);

        // Random traffic
        repeat (40) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (m[i]) prep(i, 16'($urandom), 8'($urandom_range(0, 7)), 3'($urandom));
            launch(m);
        end
        check("beat_err_clean", 64'(err_pulses), 64'd0);

        // Reset in the middle of a burst
        prep(0, 16'h1234, 8'd7, 3'd2);
        b0 = beats_seen;
        plan(2'b01);
        issue(2'b01);
        t = 0;
        while (beats_seen < b0 + 2 && t < 500) begin @(posedge ACLK); t++; end
        check("mid_burst_reached", 64'(beats_seen - b0 >= 2), 64'd1);
        #3 ARESTN = 1'b0;
        #1;
        check("rst_async_ar", 64'({ARVALID, GRANT, REQ_ARREADY}), 64'd0);
        check("rst_async_r", 64'({RREADY, REQ_RVALID, BEAT_ERR}), 64'd0);
        ptr = 0;
        repeat (2) @(negedge ACLK);
        #2 ARESTN = 1'b1;
        prep(0, 16'h2000, 8'd1, 3'd2); prep(1, 16'h3000, 8'd1, 3'd2);
        launch(2'b11);

        // Early RLAST
        e0 = err_pulses;
        trunc = 2;
        prep(0, 16'h4000, 8'd3, 3'd2);
        launch(2'b01);
        trunc = -1;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
        check("beat_err_pulse", 64'(err_pulses - e0), 64'd1);
`else
        check("beat_err_pulse", 64'(err_pulses - e0), 64'd0);
`endif
        prep(1, 16'h5000, 8'd2, 3'd2);
        launch(2'b10);
        finish_run();
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        miscompares++;
        finish_run();
    end
endmodule
